// File: rtl/usr_serial_sequencer_pkg.sv
// rtl/usr_serial_sequencer_pkg.sv - shared usr command codes and sequencer state encoding
package usr_serial_sequencer_pkg;

  localparam logic [1:0] CTRL_HOLD = 2'b00;
  localparam logic [1:0] CTRL_SHR  = 2'b01;
  localparam logic [1:0] CTRL_SHL  = 2'b10;
  localparam logic [1:0] CTRL_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

endpackage

// File: rtl/usr.sv
// rtl/usr.sv - universal shift register: hold, shift right, shift left, parallel load
module usr
  import usr_serial_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ctrl,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Register contents follow the command; shifted-in positions fill with zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      case (ctrl)
        CTRL_SHR:  q <= {1'b0, q[WIDTH-1:1]};
        CTRL_SHL:  q <= {q[WIDTH-2:0], 1'b0};
        CTRL_LOAD: q <= d;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_serial_sequencer.sv
// rtl/usr_serial_sequencer.sv - drives a usr to serialize parallel words with backpressure
module usr_serial_sequencer
  import usr_serial_sequencer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             in_ready,
  output logic [1:0]       usr_ctrl,
  output logic [WIDTH-1:0] usr_d,
  input  logic [WIDTH-1:0] usr_q,
  output logic             sout_bit,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          order;
  logic          accept;

  assign accept = in_valid && in_ready;

  // State, bit counter, and the word/bit-order captured on the accepting edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      order <= 1'b0;
      usr_d <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        usr_d <= in_data;
        order <= in_msb_first;
      end
    end
  end

  // Next state and all handshake/command outputs; in_ready is gated by reset so it drops immediately.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    usr_ctrl   = CTRL_HOLD;
    in_ready   = 1'b0;
    sout_valid = 1'b0;
    sout_last  = 1'b0;
    sout_bit   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = reset;
        if (in_valid) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        usr_ctrl  = CTRL_LOAD;
        state_nxt = SHIFT;
        cnt_nxt   = '0;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        sout_bit   = order ? usr_q[WIDTH-1] : usr_q[0];
        sout_last  = (cnt == LAST_IDX);
        if (sout_ready) begin
          usr_ctrl = order ? CTRL_SHL : CTRL_SHR;
          if (cnt == LAST_IDX) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_usr_serial_sequencer.sv
// tb/tb_usr_serial_sequencer.sv - scoreboard bench for the sequencer driving a usr
module tb_usr_serial_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_msb_first;
  logic       in_ready;
  logic [1:0] usr_ctrl;
  logic [3:0] usr_d;
  logic [3:0] usr_q;
  logic       sout_bit;
  logic       sout_valid;
  logic       sout_ready;
  logic       sout_last;

  int n_cmp = 0;
  int n_bad = 0;

  logic [1:0] exp_q[$];

  usr_serial_sequencer #(.WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_msb_first (in_msb_first),
    .in_ready     (in_ready),
    .usr_ctrl     (usr_ctrl),
    .usr_d        (usr_d),
    .usr_q        (usr_q),
    .sout_bit     (sout_bit),
    .sout_valid   (sout_valid),
    .sout_ready   (sout_ready),
    .sout_last    (sout_last)
  );

  usr #(.WIDTH(4)) u_usr (
    .clk   (clk),
    .reset (reset),
    .ctrl  (usr_ctrl),
    .d     (usr_d),
    .q     (usr_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] d, input logic msb);
    for (int i = 0; i < 4; i++) begin
      logic b;
      b = msb ? d[3-i] : d[i];
      exp_q.push_back({(i == 3), b});
    end
  endtask

  // Called in the drive phase; returns in the drive phase of the LOAD cycle.
  task automatic accept_word(input logic [3:0] d, input logic msb, input logic keep_valid);
    int k;
    in_data      = d;
    in_msb_first = msb;
    in_valid     = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 50);
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
    end
    push_word(d, msb);
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 30);
    if (!in_ready) chk(name, 0, 1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every taken serial bit is checked against the scoreboard.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (reset && sout_valid && sout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sout_bit", sout_bit, e[0]);
          chk("sout_last", sout_last, e[1]);
        end
      end
    end
  end

  initial begin
    logic [1:0] msb_ctrl [5];
    int k;
    msb_ctrl = '{2'b11, 2'b10, 2'b10, 2'b10, 2'b10};

    reset        = 1'b0;
    in_valid     = 1'b0;
    in_data      = 4'h0;
    in_msb_first = 1'b0;
    sout_ready   = 1'b1;
    #1;
    chk("in_ready_in_reset", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_usr_ctrl", usr_ctrl, 2'b00);
    chk("rst_usr_d", usr_d, 4'h0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_sout_last", sout_last, 0);
    chk("rst_sout_bit", sout_bit, 0);
    @(posedge clk);
    #1;

    // LSB-first 1001: bits 1,0,0,1, in_ready back in the 6th cycle after acceptance
    accept_word(4'b1001, 1'b0, 1'b0);
    @(negedge clk);
    chk("lsb_load_ctrl", usr_ctrl, 2'b11);
    chk("lsb_load_ready", in_ready, 0);
    chk("lsb_load_usr_d", usr_d, 4'b1001);
    k = 1;
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("lsb_ready_gap", k, 6);
    @(posedge clk);
    #1;

    // MSB-first 1011: ctrl 11,10,10,10,10 and bits 1,0,1,1
    accept_word(4'b1011, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("msb_ctrl_seq", usr_ctrl, msb_ctrl[i]);
    end
    wait_idle("msb_idle_timeout");

    // Backpressure: 0110 LSB-first, stall three cycles while bit 1 is presented
    accept_word(4'b0110, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    sout_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ctrl", usr_ctrl, 2'b00);
      chk("stall_bit", sout_bit, 1);
      chk("stall_valid", sout_valid, 1);
      chk("stall_last", sout_last, 0);
      @(posedge clk);
      #1;
    end
    sout_ready = 1'b1;
    wait_idle("bp_idle_timeout");

    // Back-to-back: 1100 then 0011 with in_valid held high
    accept_word(4'b1100, 1'b0, 1'b1);
    in_data = 4'b0011;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!in_ready && k < 20);
    chk("b2b_accept_gap", k, 6);
    chk("b2b_gap_valid0", sout_valid, 0);
    push_word(4'b0011, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_load_ctrl", usr_ctrl, 2'b11);
    chk("b2b_gap_valid1", sout_valid, 0);
    chk("b2b_load_usr_d", usr_d, 4'b0011);
    wait_idle("b2b_idle_timeout");

    // Reset during the second SHIFT bit, then 1001 serializes cleanly
    accept_word(4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_ctrl", usr_ctrl, 2'b00);
    chk("mid_rst_valid", sout_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_usr_d", usr_d, 4'h0);
    @(posedge clk);
    #1;
    accept_word(4'b1001, 1'b0, 1'b0);
    wait_idle("post_rst_idle_timeout");

    // Idle hold: nothing offered for 10 cycles
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_ctrl", usr_ctrl, 2'b00);
      chk("idle_valid", sout_valid, 0);
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
